// File: rtl/fp_addsub_pkg.sv
// Shared single-precision FP definitions for the calculator datapath
// (adder/subtractor and multiplier).
package fp_addsub_pkg;

    localparam int EXP_W      = 8;
    localparam int FRAC_W     = 23;
    localparam int BIAS       = 127;
    localparam int MANT_EXT_W = 27;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StAlign = 3'd1;
    localparam logic [2:0] StAdd   = 3'd2;
    localparam logic [2:0] StNorm  = 3'd3;
    localparam logic [2:0] StRound = 3'd4;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W:0]   mant;
        logic              is_zero;
    } fp_unpacked_t;

    // A zero exponent field denotes zero; the fraction is then ignored.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] v);
        fp_unpacked_t u;
        u.sign    = v[31];
        u.exp     = v[30:23];
        u.is_zero = (v[30:23] == 8'd0);
        u.mant    = u.is_zero ? 24'd0 : {1'b1, v[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 24-bit mantissa with guard/round/sticky bits.
module fp_round_rne
    import fp_addsub_pkg::*;
(
    input  logic [FRAC_W:0] mant,
    input  logic            g,
    input  logic            r,
    input  logic            s,
    output logic [FRAC_W:0] mant_rnd,
    output logic            carry
);

    logic inc;

    assign inc = g & (r | s | mant[0]);
    assign {carry, mant_rnd} = {1'b0, mant} + {24'd0, inc};

endmodule

// File: rtl/fp_addsub.sv
// Sequential IEEE-754 single-precision adder/subtractor with a Start/adddone
// one-shot handshake; normal and zero operands only.
module fp_addsub
    import fp_addsub_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        op,
    input  logic [31:0] X,
    input  logic [31:0] Y,
    output logic        adddone,
    output logic [31:0] FPS
);

    logic [2:0]            state_q, state_d;
    logic [MANT_EXT_W-1:0] a_q, a_d;
    logic [MANT_EXT_W-1:0] b_q, b_d;
    logic [MANT_EXT_W:0]   sum_q, sum_d;
    logic [7:0]            d_q, d_d;
    logic [9:0]            exp_q, exp_d;
    logic                  sign_q, sign_d;
    logic                  sub_q, sub_d;
    logic                  zero_q, zero_d;
    logic [31:0]           fps_q, fps_d;
    logic                  done_q;

    fp_unpacked_t ux, uy;
    logic         x_ge;
    logic [23:0]  rnd_mant;
    logic         rnd_carry;
    logic [9:0]   exp_fin;
    logic         unused_hidden;

    assign ux = fp_unpack(X);
    assign uy = fp_unpack(Y);

    // Zero operands rank below every normal regardless of fraction; ties keep X in A.
    assign x_ge = ux.is_zero ? uy.is_zero : (uy.is_zero || (X[30:0] >= Y[30:0]));

    fp_round_rne u_round (
        .mant     (sum_q[26:3]),
        .g        (sum_q[2]),
        .r        (sum_q[1]),
        .s        (sum_q[0]),
        .mant_rnd (rnd_mant),
        .carry    (rnd_carry)
    );

    assign exp_fin       = exp_q + {9'd0, rnd_carry};
    assign unused_hidden = rnd_mant[23];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        d_d     = d_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        zero_d  = zero_q;
        fps_d   = fps_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    sub_d  = ux.sign ^ uy.sign ^ op;
                    zero_d = 1'b0;
                    if (x_ge) begin
                        a_d    = {ux.mant, 3'b000};
                        b_d    = {uy.mant, 3'b000};
                        exp_d  = {2'b00, ux.exp};
                        d_d    = ux.exp - uy.exp;
                        sign_d = ux.sign;
                    end else begin
                        a_d    = {uy.mant, 3'b000};
                        b_d    = {ux.mant, 3'b000};
                        exp_d  = {2'b00, uy.exp};
                        d_d    = uy.exp - ux.exp;
                        sign_d = uy.sign ^ op;
                    end
                    state_d = StAlign;
                end
            end
            StAlign: begin
                if (d_q >= 8'd27) begin
                    b_d = {26'd0, |b_q};
                    d_d = 8'd0;
                end else if (d_q != 8'd0) begin
                    // Bit 0 is the sticky bit and absorbs everything shifted past it.
                    b_d = {1'b0, b_q[26:2], b_q[1] | b_q[0]};
                    d_d = d_q - 8'd1;
                end else begin
                    state_d = StAdd;
                end
            end
            StAdd: begin
                sum_d   = sub_q ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});
                state_d = StNorm;
            end
            StNorm: begin
                if (sum_q == '0) begin
                    zero_d  = 1'b1;
                    state_d = StRound;
                end else if (sum_q[27]) begin
                    sum_d   = {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
                    exp_d   = exp_q + 10'd1;
                    state_d = StRound;
                end else if (!sum_q[26]) begin
                    sum_d = {sum_q[26:0], 1'b0};
                    exp_d = exp_q - 10'd1;
                end else begin
                    state_d = StRound;
                end
            end
            StRound: begin
                if (zero_q) begin
                    fps_d = 32'd0;
                end else if ($signed(exp_fin) <= 10'sd0) begin
                    fps_d = {sign_q, 31'd0};
                end else if ($signed(exp_fin) >= 10'sd255) begin
                    fps_d = {sign_q, 8'hFF, 23'd0};
                end else begin
                    fps_d = {sign_q, exp_fin[7:0], rnd_mant[22:0]};
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            d_q     <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            zero_q  <= 1'b0;
            fps_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            d_q     <= d_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            zero_q  <= zero_d;
            fps_q   <= fps_d;
            done_q  <= (state_q == StRound);
        end
    end

    assign adddone = done_q;
    assign FPS     = fps_q;

endmodule

// File: tb/tb_fp_addsub.sv
// Self-checking bench for fp_addsub: exact-arithmetic reference model, per-cycle
// compare process and directed vectors with hand-computed results.
module tb_fp_addsub;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] X = 32'd0;
    logic [31:0] Y = 32'd0;
    logic        adddone;
    logic [31:0] FPS;

    int errors = 0;
    int checks = 0;

    fp_addsub dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .op      (op),
        .X       (X),
        .Y       (Y),
        .adddone (adddone),
        .FPS     (FPS)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkint(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Exact sum on wide integers, then RNE to 24 bits; latency from the
    // alignment distance and the exponent drop of the exact result.
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic o, output int lat);
        logic [299:0] va, vb, mag, kept, rem, half, one;
        int ex, ey, emin, emax, p, sh, e, d, dp, k;
        logic sx, sy, sr, up;
        one  = 300'd1;
        sx   = x[31];
        sy   = y[31] ^ o;
        ex   = int'(x[30:23]);
        ey   = int'(y[30:23]);
        va   = (ex == 0) ? '0 : {276'd0, 1'b1, x[22:0]};
        vb   = (ey == 0) ? '0 : {276'd0, 1'b1, y[22:0]};
        emin = (ex < ey) ? ex : ey;
        emax = (ex < ey) ? ey : ex;
        va   = va << (ex - emin);
        vb   = vb << (ey - emin);
        if (sx == sy) begin
            mag = va + vb; sr = sx;
        end else if (va >= vb) begin
            mag = va - vb; sr = sx;
        end else begin
            mag = vb - va; sr = sy;
        end
        d  = emax - emin;
        dp = (d < 27) ? d : 1;
        if (mag == '0) begin
            lat = 5 + dp;
            return 32'd0;
        end
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        k = emax - (emin + p - 23);
        if (k < 0) k = 0;
        lat = 5 + dp + k;
        if (p > 23) begin
            sh   = p - 23;
            kept = mag >> sh;
            rem  = mag & ((one << sh) - one);
            half = one << (sh - 1);
            up   = (rem > half) || ((rem == half) && kept[0]);
            kept = kept + {299'd0, up};
            e    = emin + sh;
            if (kept[24]) begin
                kept = kept >> 1;
                e++;
            end
        end else begin
            kept = mag << (23 - p);
            e    = emin - (23 - p);
        end
        if (e <= 0) return {sr, 31'd0};
        if (e >= 255) return {sr, 8'hFF, 23'd0};
        return {sr, e[7:0], kept[22:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: predicts every edge from the handshake rules and checks outputs each cycle.
    initial begin
        logic        armed = 1'b0;
        logic        busy = 1'b0;
        logic        done_exp = 1'b0;
        logic [31:0] hold_fps = 32'd0;
        logic [31:0] pend = 32'd0;
        int          cnt = 0;
        int          lat;
        forever begin
            @(negedge clk);
            if (armed) begin
                checkint("cycle adddone", int'(adddone), int'(done_exp));
                check32("cycle FPS", FPS, hold_fps);
            end
            if (reset) begin
                armed    = 1'b1;
                busy     = 1'b0;
                done_exp = 1'b0;
                hold_fps = 32'd0;
            end else begin
                done_exp = 1'b0;
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        done_exp = 1'b1;
                        hold_fps = pend;
                        busy     = 1'b0;
                    end
                end else if (Start) begin
                    pend = model(X, Y, op, lat);
                    cnt  = lat - 1;
                    busy = 1'b1;
                end
            end
        end
    end

    task automatic do_op(input string name, input logic [31:0] x, input logic [31:0] y,
                         input logic o, input logic [31:0] exp_fps, input int exp_lat);
        int          mlat, n;
        logic [31:0] m;
        m = model(x, y, o, mlat);
        check32({name, " model"}, m, exp_fps);
        checkint({name, " model_lat"}, mlat, exp_lat);
        X = x; Y = y; op = o; Start = 1'b1;
        tick();
        n = 1;
        Start = 1'b0;
        // Operands are captured; scramble the inputs to prove it.
        X = ~x; Y = x ^ y; op = ~o;
        while (!adddone && n < 200) begin
            tick();
            n++;
        end
        if (!adddone) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no adddone within %0d edges", name, n);
        end else begin
            check32(name, FPS, exp_fps);
            checkint({name, " lat"}, n, exp_lat);
        end
    endtask

    initial begin
        int          n, done_cnt, mlat;
        logic [31:0] m;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check32("reset FPS", FPS, 32'd0);
        checkint("reset adddone", int'(adddone), 0);
        tick();

        do_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5);
        do_op("cancel",       32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 5);
        do_op("tie_even",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 29);
        do_op("deep_norm",    32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 30);
        do_op("tie_odd",      32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 29);
        do_op("round_carry",  32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 29);
        do_op("collapse_sub", 32'h3F800000, 32'h2F800000, 1'b1, 32'h3F800000, 7);
        do_op("zero_plus_y",  32'h00000000, 32'hC0490FDB, 1'b0, 32'hC0490FDB, 6);
        do_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5);
        do_op("underflow",    32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 6);
        do_op("zero_zero",    32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 5);

        // Second Start while aligning must be ignored.
        m = model(32'h40000000, 32'h40400000, 1'b1, mlat);
        check32("swap model", m, 32'hBF800000);
        checkint("swap model_lat", mlat, 6);
        X = 32'h40000000; Y = 32'h40400000; op = 1'b1; Start = 1'b1;
        tick();
        n = 1;
        X = 32'h3F800000; Y = 32'h3F800000; op = 1'b0;
        tick();
        n++;
        Start = 1'b0;
        while (!adddone && n < 200) begin
            tick();
            n++;
        end
        check32("swap FPS", FPS, 32'hBF800000);
        checkint("swap lat", n, 6);
        done_cnt = adddone ? 1 : 0;
        repeat (10) begin
            tick();
            if (adddone) done_cnt++;
        end
        checkint("swap pulses", done_cnt, 1);

        // Reset in the middle of a long alignment discards the operation.
        X = 32'h3F800000; Y = 32'h33800000; op = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check32("reset_abort FPS now", FPS, 32'd0);
        done_cnt = 0;
        repeat (40) begin
            tick();
            if (adddone) done_cnt++;
        end
        checkint("reset_abort pulses", done_cnt, 0);
        check32("reset_abort FPS", FPS, 32'd0);
        do_op("after_reset", 32'h40000000, 32'h00000000, 1'b0, 32'h40000000, 6);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
